// File: rtl/lsu_stage.sv
// Load/store stage: accepts one EXU payload, performs at most one bus access, then hands a
// 38-bit write-back payload to the WBU. Optional misalignment trap: LSU_MISALIGN_CHECK_EN.
module lsu_stage #(
  parameter int WIDTH      = 32,
  parameter int DATA_IN_W  = 109,
  parameter int DATA_OUT_W = 38
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  input  logic [DATA_IN_W-1:0]  exu_data,
  output logic                  lsu_ready,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [WIDTH-1:0]      mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  lsu_valid,
  output logic [DATA_OUT_W-1:0] lsu_data,
  input  logic                  wbu_ready
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                  lsu_fault
`endif
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REQ       = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;
  localparam logic [1:0] S_OUT       = 2'd3;

  logic [WIDTH-1:0] alu_in, rs2_in, csr_in;
  logic [4:0]       rd_in;
  logic             rwen_in, ren_in, wen_in;
  logic [2:0]       f3_in;
  logic [1:0]       sel_in;

  assign alu_in  = exu_data[108:77];
  assign rs2_in  = exu_data[76:45];
  assign rd_in   = exu_data[44:40];
  assign rwen_in = exu_data[39];
  assign ren_in  = exu_data[38];
  assign wen_in  = exu_data[37];
  assign f3_in   = exu_data[36:34];
  assign sel_in  = exu_data[33:32];
  assign csr_in  = exu_data[31:0];

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      addr_q, csr_q, wdata_q, wdata_d;
  logic [4:0]            rd_q;
  logic                  rwen_q, store_q;
  logic [2:0]            f3_q;
  logic [1:0]            sel_q;
  logic [3:0]            wmask_q, wmask_d;
  logic [DATA_OUT_W-1:0] out_q, out_d;

  logic accept, is_mem_in, misalign_in;

  assign accept    = exu_valid & lsu_ready;
  assign is_mem_in = ren_in | wen_in;

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign_in = 1'b0;
    if (is_mem_in) begin
      if (f3_in[1:0] == 2'b01)      misalign_in = alu_in[0];
      else if (f3_in[1:0] == 2'b10) misalign_in = (alu_in[1:0] != 2'b00);
    end
  end
`else
  assign misalign_in = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] load_align(input logic [2:0] f3,
                                                  input logic [1:0] a,
                                                  input logic [WIDTH-1:0] rdata);
    logic [WIDTH-1:0] sh;
    sh = rdata >> {a, 3'b000};
    case (f3)
      3'b000:  load_align = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_align = {24'h0, sh[7:0]};
      3'b001:  load_align = {{16{sh[15]}}, sh[15:0]};
      3'b101:  load_align = {16'h0, sh[15:0]};
      default: load_align = sh;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] wb_select(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] alu,
                                                 input logic [WIDTH-1:0] ld,
                                                 input logic [WIDTH-1:0] csr);
    case (sel)
      2'd1:    wb_select = ld;
      2'd2:    wb_select = csr;
      default: wb_select = alu;
    endcase
  endfunction

  // Lanes wrap inside the word; the shifted mask is truncated to 4 bits.
  always_comb begin
    case (f3_in[1:0])
      2'b00: begin
        wmask_d = 4'b0001 << alu_in[1:0];
        wdata_d = {4{rs2_in[7:0]}};
      end
      2'b01: begin
        wmask_d = 4'b0011 << alu_in[1:0];
        wdata_d = {2{rs2_in[15:0]}};
      end
      default: begin
        wmask_d = 4'b1111;
        wdata_d = rs2_in;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mem_in && !misalign_in) begin
            state_d = S_REQ;
          end else begin
            state_d = S_OUT;
            out_d   = {wb_select(sel_in, alu_in, '0, csr_in), rd_in,
                       rwen_in & ~wen_in & ~misalign_in};
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (mem_resp_valid) begin
          state_d = S_OUT;
          out_d   = {wb_select(sel_q, addr_q,
                               store_q ? '0 : load_align(f3_q, addr_q[1:0], mem_rdata),
                               csr_q),
                     rd_q, rwen_q};
        end
      end
      S_OUT: begin
        if (wbu_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      csr_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rd_q    <= '0;
      rwen_q  <= 1'b0;
      store_q <= 1'b0;
      f3_q    <= '0;
      sel_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (accept) begin
        addr_q  <= alu_in;
        csr_q   <= csr_in;
        rd_q    <= rd_in;
        rwen_q  <= rwen_in & ~wen_in;
        store_q <= wen_in;
        f3_q    <= f3_in;
        sel_q   <= sel_in;
        wdata_q <= wen_in ? wdata_d : '0;
        wmask_q <= wen_in ? wmask_d : 4'b0000;
      end
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst)         fault_q <= 1'b0;
    else if (accept) fault_q <= misalign_in;
  end

  assign lsu_fault = fault_q & (state_q == S_OUT);
`endif

  assign lsu_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_wen       = store_q & (state_q == S_REQ);
  assign mem_addr      = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign lsu_valid     = (state_q == S_OUT);
  assign lsu_data      = out_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage; inputs driven and outputs sampled on the falling edge.
module tb_lsu_stage;

  logic        clk;
  logic        rst;
  logic        exu_valid;
  logic [108:0] exu_data;
  logic        lsu_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        lsu_valid;
  logic [37:0] lsu_data;
  logic        wbu_ready;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        lsu_fault;
`endif

  int n_checks = 0;
  int n_errors = 0;

  lsu_stage dut (
    .clk            (clk),
    .rst            (rst),
    .exu_valid      (exu_valid),
    .exu_data       (exu_data),
    .lsu_ready      (lsu_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .lsu_valid      (lsu_valid),
    .lsu_data       (lsu_data),
    .wbu_ready      (wbu_ready)
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    .lsu_fault      (lsu_fault)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [108:0] pack(input logic [31:0] alu, input logic [31:0] rs2,
                                        input logic [4:0] rd, input logic rwen,
                                        input logic ren, input logic wen,
                                        input logic [2:0] f3, input logic [1:0] sel,
                                        input logic [31:0] csr);
    return {alu, rs2, rd, rwen, ren, wen, f3, sel, csr};
  endfunction

  task automatic send(input logic [108:0] p);
    exu_valid = 1'b1;
    exu_data  = p;
    @(negedge clk);
    exu_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    mem_req_ready = 1'b1;
    wbu_ready     = 1'b1;
    send(pack(addr, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, f3, 2'd1, 32'h0));
    check({tag, " req_valid"}, mem_req_valid, 1);
    check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, " wen"}, mem_wen, 0);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check({tag, " valid"}, lsu_valid, 1);
    check({tag, " data"}, lsu_data, {exp, 5'd7, 1'b1});
    @(negedge clk);
    check({tag, " ready_after"}, lsu_ready, 1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [3:0] mask,
                          input logic [31:0] wdata);
    mem_req_ready = 1'b1;
    wbu_ready     = 1'b1;
    send(pack(addr, rs2, 5'd3, 1'b1, 1'b0, 1'b1, f3, 2'd0, 32'h0));
    check({tag, " req_valid"}, mem_req_valid, 1);
    check({tag, " wen"}, mem_wen, 1);
    check({tag, " mask"}, mem_wmask, mask);
    check({tag, " wdata"}, mem_wdata, wdata);
    check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check({tag, " valid"}, lsu_valid, 1);
    check({tag, " data"}, lsu_data, {addr, 5'd3, 1'b0});
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    exu_valid      = 1'b0;
    exu_data       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    wbu_ready      = 1'b0;

    repeat (2) @(negedge clk);
    check("rst lsu_valid", lsu_valid, 0);
    check("rst req_valid", mem_req_valid, 0);
    check("rst wmask", mem_wmask, 0);
    check("rst lsu_data", lsu_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst lsu_ready", lsu_ready, 1);

    // non-memory op, one-cycle latency
    wbu_ready = 1'b1;
    send(pack(32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0));
    check("alu valid", lsu_valid, 1);
    check("alu data", lsu_data, {32'h1234_5678, 5'd5, 1'b1});
    check("alu no req", mem_req_valid, 0);
    check("alu not ready", lsu_ready, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("alu no fault", lsu_fault, 0);
`endif
    @(negedge clk);
    check("alu done", lsu_valid, 0);
    check("alu ready", lsu_ready, 1);

    send(pack(32'h0BAD_CAFE, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 3'b000, 2'd3, 32'h1111_2222));
    check("sel3 data", lsu_data, {32'h0BAD_CAFE, 5'd6, 1'b1});
    @(negedge clk);

    do_load("LB",  3'b000, 32'h8000_0003, 32'h80AA_BBCC, 32'hFFFF_FF80);
    do_load("LBU", 3'b100, 32'h8000_0003, 32'h80AA_BBCC, 32'h0000_0080);
    do_load("LH",  3'b001, 32'h8000_0002, 32'h80AA_BBCC, 32'hFFFF_80AA);
    do_load("LHU", 3'b101, 32'h8000_0002, 32'h80AA_BBCC, 32'h0000_80AA);
    do_load("LW",  3'b010, 32'h8000_0004, 32'h80AA_BBCC, 32'h80AA_BBCC);

    do_store("SH", 3'b001, 32'h8000_0002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_store("SB", 3'b000, 32'h8000_0001, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    do_store("SW", 3'b010, 32'h8000_0008, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F);
`ifndef LSU_MISALIGN_CHECK_EN
    do_store("SH wrap", 3'b001, 32'h8000_0003, 32'h0000_BEEF, 4'b1000, 32'hBEEF_BEEF);
`endif

    // bus backpressure
    mem_req_ready = 1'b0;
    wbu_ready     = 1'b1;
    send(pack(32'h8000_0010, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h0));
    for (int i = 0; i < 3; i++) begin
      check("bp req_valid", mem_req_valid, 1);
      check("bp addr", mem_addr, 32'h8000_0010);
      check("bp not ready", lsu_ready, 0);
      if (i < 2) @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("bp req dropped", mem_req_valid, 0);
    check("bp wait not ready", lsu_ready, 0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("bp data", lsu_data, {32'hDEAD_BEEF, 5'd8, 1'b1});
    check("bp out not ready", lsu_ready, 0);
    @(negedge clk);
    check("bp ready", lsu_ready, 1);

    // write-back stall with a competing EXU payload
    wbu_ready = 1'b0;
    send(pack(32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000, 2'd2, 32'hCAFE_F00D));
    exu_valid = 1'b1;
    exu_data  = pack(32'h5555_5555, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("stall valid", lsu_valid, 1);
      check("stall data", lsu_data, {32'hCAFE_F00D, 5'd9, 1'b1});
      check("stall not ready", lsu_ready, 0);
      @(negedge clk);
    end
    exu_valid = 1'b0;
    wbu_ready = 1'b1;
    @(negedge clk);
    check("stall released", lsu_valid, 0);
    @(negedge clk);
    check("stall no extra", lsu_valid, 0);

    // reset while waiting for a response
    mem_req_ready = 1'b1;
    send(pack(32'h8000_0020, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h0));
    @(negedge clk);
    check("rstw in wait", mem_req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("rstw no valid", lsu_valid, 0);
    check("rstw ready", lsu_ready, 1);
    check("rstw no req", mem_req_valid, 0);

`ifdef LSU_MISALIGN_CHECK_EN
    send(pack(32'h8000_0002, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h0));
    check("mis no req", mem_req_valid, 0);
    check("mis valid", lsu_valid, 1);
    check("mis fault", lsu_fault, 1);
    check("mis rwen", lsu_data[0], 0);
    @(negedge clk);
    check("mis fault clear", lsu_fault, 0);
    check("mis ready", lsu_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store stage of the multicycle core; consumer end of the EXU→LSU valid/ready handshake.
- Captures the 109-bit EXU payload and performs at most one memory transaction per instruction over a simple request/response bus.
- Aligns and extends load data, selects the write-back value, and presents a 38-bit payload to the WBU under its own valid/ready handshake.

Parameters:
- WIDTH, 32, datapath and address width (only 32 supported).
- DATA_IN_W, 109, width of exu_data.
- DATA_OUT_W, 38, width of lsu_data.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- exu_valid  input  1  EXU payload valid
- exu_data  input  109  EXU payload, layout below
- lsu_ready  output  1  stage can accept a payload
- mem_req_valid  output  1  bus request valid
- mem_req_ready  input  1  bus accepts request
- mem_wen  output  1  request is a store
- mem_addr  output  32  byte address, low 2 bits forced to 0
- mem_wdata  output  32  lane-shifted store data
- mem_wmask  output  4  byte-lane write mask
- mem_resp_valid  input  1  response valid, one cycle
- mem_rdata  input  32  read word
- lsu_valid  output  1  write-back payload valid
- lsu_data  output  38  {wb_data[31:0], rd[4:0], reg_wen}
- wbu_ready  input  1  WBU accepts payload

Behaviour:
- exu_data layout:
  - [108:77] alu_result (address or result)
  - [76:45] rs2_data
  - [44:40] rd
  - [39] reg_wen
  - [38] mem_ren
  - [37] mem_wen
  - [36:34] funct3
  - [33:32] wb_sel
  - [31:0] csr_data
- States: S_IDLE, S_REQ, S_WAIT_RESP, S_OUT.
- lsu_ready = (state==S_IDLE). Accept on exu_valid & lsu_ready; payload registered that edge.
- From S_IDLE on accept:
  - mem_ren|mem_wen → S_REQ.
  - Otherwise → S_OUT.
- S_REQ:
  - mem_req_valid=1; address, data and mask are held stable until mem_req_ready.
  - On mem_req_ready → S_WAIT_RESP.
- S_WAIT_RESP:
  - Stores and loads both wait for mem_resp_valid.
  - Loads capture mem_rdata on mem_resp_valid, then → S_OUT.
  - Responses arriving in any other state are ignored.
- S_OUT:
  - lsu_valid=1; lsu_data is held stable.
  - On wbu_ready → S_IDLE; lsu_ready rises the following cycle.
- Latency:
  - Non-memory op accepted at edge N: lsu_valid high in cycle N+1.
  - Memory op with zero-wait bus: lsu_valid high in cycle N+3 (REQ N+1, WAIT N+2, OUT N+3).
- Store lanes, with a = alu_result[1:0]:
  - SB (funct3=000): mask = 4'b0001<<a; wdata = rs2[7:0] replicated in all 4 lanes.
  - SH (001): mask = 4'b0011<<a; wdata = rs2[15:0] replicated in both halves.
  - SW (010): mask = 4'b1111; wdata = rs2.
- Load extraction: shift mem_rdata right by 8*a, then:
  - LB sign-extends 8 bits; LBU (100) zero-extends 8 bits.
  - LH sign-extends 16 bits; LHU (101) zero-extends 16 bits.
  - LW passes all 32 bits.
- wb_data selection:
  - wb_sel=0: alu_result.
  - wb_sel=1: aligned load data.
  - wb_sel=2: csr_data.
  - wb_sel=3: alu_result.
- Stores force reg_wen=0 in lsu_data. mem_ren and mem_wen both set is treated as a store.
- Reset: state=S_IDLE; lsu_valid=0; mem_req_valid=0; mem_wmask=0; lsu_data=0; lsu_ready=1 the cycle after reset deasserts.
- Reset mid-transaction abandons the access; any later mem_resp_valid is ignored in S_IDLE.
- Misaligned access (no macro): the bus sees the word address; lanes wrap within the word, mask truncated to 4 bits.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- With the macro defined:
  - A halfword access with a[0]=1, or a word access with a≠0, issues no bus request.
  - Flow goes S_IDLE→S_OUT with reg_wen=0.
  - Added output port lsu_fault (1 bit) = 1 while that payload is valid, otherwise 0; reset 0.
- Without the macro: port absent; wrap behaviour as above.

Test Plan:
- Non-memory op, alu_result=0x12345678, wb_sel=0, rd=5, reg_wen=1, wbu_ready=1 → lsu_valid one cycle after accept; lsu_data={0x12345678,5'd5,1}; mem_req_valid never asserted.
- LB at addr 0x80000003, mem_rdata=0x80AABBCC → mem_addr=0x80000000; wb_data=0xFFFFFF80. LBU at the same address → wb_data=0x00000080.
- SH at addr 0x80000002, rs2=0x0000BEEF → mem_wen=1, mem_wmask=4'b1100, mem_wdata=0xBEEFBEEF; lsu_data reg_wen=0.
- Bus backpressure: mem_req_ready held low for 3 cycles → mem_req_valid and mem_addr stable throughout; lsu_ready=0 until write-back completes.
- WBU stall: wbu_ready low for 4 cycles in S_OUT → lsu_valid and lsu_data unchanged; exu_valid asserted meanwhile is not accepted.
- rst pulsed in S_WAIT_RESP, then mem_resp_valid → no lsu_valid; lsu_ready=1 the cycle after reset deasserts. With LSU_MISALIGN_CHECK_EN, LW at 0x80000002 → no bus request; lsu_fault=1.
